// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : memory_stage
// Description : RISC-V memory-access stage. Issues word loads/stores over a
//               req/ready + rvalid handshake, stalls while an access is
//               outstanding, and owns the M/W pipeline register.
//               Optional feature macro: MEM_MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_M
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_GNT  = 2'd1,
        ST_WAIT_DATA = 2'd2
    } state_t;

    state_t r_state;

    logic w_mem_op;
    logic w_misalign;
    logic w_issue;
    logic w_load_done;

    assign w_mem_op = MemWriteM | ResultSrcM;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misalign = w_mem_op & (ALU_ResultM[1:0] != 2'b00);
    assign dmem_addr  = ALU_ResultM;
`else
    // Misaligned accesses are silently forced onto the containing word.
    assign w_misalign = 1'b0;
    assign dmem_addr  = {ALU_ResultM[31:2], 2'b00};
`endif

    assign w_issue     = w_mem_op & ~w_misalign;
    assign dmem_we     = MemWriteM;
    assign dmem_wdata  = WriteDataM;
    assign w_load_done = (r_state == ST_WAIT_DATA) & dmem_rvalid;

    // A store completes in the cycle it is granted; a load always waits for rvalid.
    always_comb begin
        dmem_req = 1'b0;
        StallM   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                dmem_req = w_issue;
                StallM   = w_issue & (ResultSrcM | ~dmem_ready);
            end
            ST_WAIT_GNT: begin
                dmem_req = 1'b1;
                StallM   = ~(dmem_ready & MemWriteM);
            end
            ST_WAIT_DATA: begin
                StallM   = ~dmem_rvalid;
            end
            default: begin
                dmem_req = 1'b0;
                StallM   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        if (!dmem_ready)
                            r_state <= ST_WAIT_GNT;
                        else if (ResultSrcM)
                            r_state <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_GNT: begin
                    if (dmem_ready)
                        r_state <= MemWriteM ? ST_IDLE : ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (dmem_rvalid)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // M/W register: a stall inserts a bubble by clearing only RegWriteW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 1'b0;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
        end else if (!StallM) begin
            RegWriteW   <= RegWriteM & ~w_misalign;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            if (w_load_done)
                ReadDataW <= dmem_rdata;
        end else begin
            RegWriteW   <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            misalign_M <= 1'b0;
        else
            misalign_M <= ~StallM & w_misalign;
    end
`endif

endmodule
`default_nettype wire
